crypto_sequencer: RTL and testbench

- Sequences one crypto core operation per request on the crypt_clk domain, between the register block (key/text/go/status) and the crypto core block interface (start/ready/done/cipher).
- Latches operands, waits for core ready, issues a single start pulse, and qualifies core done.
- Captures ciphertext and the measured latency, drives the scope trigger, and enforces an optional timeout.

---
 rtl/crypto_seq_pkg.sv | 25 ++
 rtl/crypto_sequencer_lfsr.sv | 28 ++
 rtl/crypto_sequencer.sv | 151 +++++++++++++++
 tb/tb_crypto_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crypto_seq_pkg.sv
// Shared types and constants for the crypto operation sequencer.
// Holds the state encoding, default widths and the jitter LFSR feedback polynomial.
package crypto_seq_pkg;

    localparam int DEF_KEY_W  = 128;
    localparam int DEF_TEXT_W = 128;
    localparam int DEF_CNT_W  = 16;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_DELAY    = 3'd2,
        S_START    = 3'd3,
        S_RUN      = 3'd4,
        S_CAPTURE  = 3'd5
    } seq_state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {1'b0, cur[15:1]} ^ (cur[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/crypto_sequencer_lfsr.sv
// seq_lfsr: 16-bit Galois LFSR, loads SEED on reset and advances on every enabled cycle.
// Latency: new value visible one cycle after each enabled edge.
// Backpressure: none; en simply freezes the sequence.
module seq_lfsr
    import crypto_seq_pkg::*;
#(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 4
) (
    input  logic             crypt_clk,
    input  logic             crypt_rst_n,
    input  logic             en,
    output logic [OUT_W-1:0] rnd
);

    logic [15:0] lfsr_q;

    always_ff @(posedge crypt_clk or negedge crypt_rst_n) begin
        if (!crypt_rst_n) begin
            lfsr_q <= SEED;
        end else if (en) begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/crypto_sequencer.sv
// crypto_sequencer: latches operands on go, starts the core once, qualifies done, captures result and latency.
// Latency: go to core_start 2 cycles with core_ready high; CRYPTO_RAND_DELAY_EN adds 1..16 DELAY cycles of jitter.
// Backpressure: holds in WAIT_RDY until core_ready; go outside IDLE is dropped, optional timeout aborts RUN.
module crypto_sequencer
    import crypto_seq_pkg::*;
#(
    parameter int          KEY_W     = DEF_KEY_W,
    parameter int          TEXT_W    = DEF_TEXT_W,
    parameter int          CNT_W     = DEF_CNT_W,
    parameter logic [15:0] RAND_SEED = 16'hACE1
) (
    input  logic              crypt_clk,
    input  logic              crypt_rst_n,
    input  logic              go,
    input  logic [KEY_W-1:0]  key_in,
    input  logic [TEXT_W-1:0] text_in,
    input  logic [CNT_W-1:0]  timeout_limit,
    output logic [KEY_W-1:0]  core_key,
    output logic [TEXT_W-1:0] core_text,
    output logic              core_start,
    input  logic              core_ready,
    input  logic              core_done,
    input  logic [TEXT_W-1:0] core_cipher,
    output logic [TEXT_W-1:0] cipher_out,
    output logic [CNT_W-1:0]  cycles,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              trigger
);

    if (RAND_SEED == 16'h0000) begin : g_seed_check
        $error("RAND_SEED must be nonzero");
    end

    seq_state_t       state;
    logic [CNT_W-1:0] counter;
    logic             armed;
    logic             qual_done;
    logic             limit_hit;

`ifdef CRYPTO_RAND_DELAY_EN
    logic [3:0] rnd;
    logic [3:0] delay;

    seq_lfsr #(
        .SEED  (RAND_SEED),
        .OUT_W (4)
    ) u_lfsr (
        .crypt_clk   (crypt_clk),
        .crypt_rst_n (crypt_rst_n),
        .en          (1'b1),
        .rnd         (rnd)
    );
`endif

    // Cores whose done is ~busy sit high before start; done only counts after a low was seen.
    assign qual_done = core_done & armed;
    assign limit_hit = (timeout_limit != '0) && (counter == timeout_limit);

    always_ff @(posedge crypt_clk or negedge crypt_rst_n) begin
        if (!crypt_rst_n) begin
            state      <= S_IDLE;
            counter    <= '0;
            armed      <= 1'b0;
            core_key   <= '0;
            core_text  <= '0;
            core_start <= 1'b0;
            cipher_out <= '0;
            cycles     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            trigger    <= 1'b0;
`ifdef CRYPTO_RAND_DELAY_EN
            delay      <= '0;
`endif
        end else begin
            core_start <= 1'b0;
            done       <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (go) begin
                        core_key  <= key_in;
                        core_text <= text_in;
                        timeout   <= 1'b0;
                        counter   <= '0;
                        busy      <= 1'b1;
                        state     <= S_WAIT_RDY;
                    end
                end
                S_WAIT_RDY: begin
                    if (core_ready) begin
`ifdef CRYPTO_RAND_DELAY_EN
                        delay      <= rnd;
                        state      <= S_DELAY;
`else
                        core_start <= 1'b1;
                        trigger    <= 1'b1;
                        state      <= S_START;
`endif
                    end
                end
`ifdef CRYPTO_RAND_DELAY_EN
                S_DELAY: begin
                    if (delay == 4'd0) begin
                        core_start <= 1'b1;
                        trigger    <= 1'b1;
                        state      <= S_START;
                    end else begin
                        delay <= delay - 4'd1;
                    end
                end
`endif
                S_START: begin
                    counter <= CNT_W'(1);
                    armed   <= 1'b0;
                    state   <= S_RUN;
                end
                S_RUN: begin
                    if (!core_done) begin
                        armed <= 1'b1;
                    end
                    // Result, latency and the done pulse all become visible together in CAPTURE.
                    if (qual_done) begin
                        cipher_out <= core_cipher;
                        cycles     <= counter;
                        done       <= 1'b1;
                        trigger    <= 1'b0;
                        state      <= S_CAPTURE;
                    end else if (limit_hit) begin
                        timeout <= 1'b1;
                        busy    <= 1'b0;
                        trigger <= 1'b0;
                        state   <= S_IDLE;
                    end else if (counter != '1) begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_sequencer.sv
// Bench for crypto_sequencer: per-operation timeline model plus scripted core, checked every cycle.
module tb_crypto_sequencer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic         crypt_clk = 1'b0;
    logic         crypt_rst_n = 1'b0;
    logic         go = 1'b0;
    logic [127:0] key_in = '0;
    logic [127:0] text_in = '0;
    logic [15:0]  timeout_limit = '0;
    logic [127:0] core_key;
    logic [127:0] core_text;
    logic         core_start;
    logic         core_ready = 1'b1;
    logic         core_done = 1'b0;
    logic [127:0] core_cipher = '0;
    logic [127:0] cipher_out;
    logic [15:0]  cycles;
    logic         busy;
    logic         done;
    logic         timeout;
    logic         trigger;

    crypto_sequencer #(
        .KEY_W     (128),
        .TEXT_W    (128),
        .CNT_W     (16),
        .RAND_SEED (SEED)
    ) dut (
        .crypt_clk     (crypt_clk),
        .crypt_rst_n   (crypt_rst_n),
        .go            (go),
        .key_in        (key_in),
        .text_in       (text_in),
        .timeout_limit (timeout_limit),
        .core_key      (core_key),
        .core_text     (core_text),
        .core_start    (core_start),
        .core_ready    (core_ready),
        .core_done     (core_done),
        .core_cipher   (core_cipher),
        .cipher_out    (cipher_out),
        .cycles        (cycles),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .trigger       (trigger)
    );

    always #5 crypt_clk = ~crypt_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int p_go = 0;
    int last_start_cyc = -1;

    // Model state: what each output must show in the current cycle.
    logic [127:0] m_key = '0, m_text = '0, m_cipher = '0;
    logic [15:0]  m_cycles = '0;
    logic         m_timeout = 1'b0;
    logic         exp_busy = 1'b0, exp_start = 1'b0, exp_trig = 1'b0, exp_done = 1'b0;
    logic [15:0]  m_lfsr = SEED;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        if (v[0]) return (v >> 1) ^ 16'hB400;
        return v >> 1;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge crypt_clk) begin
        cyc = cyc + 1;
        if (!crypt_rst_n) m_lfsr = SEED;
        else              m_lfsr = lfsr_step(m_lfsr);
    end

    always @(negedge crypt_clk) begin
        chk("core_key", core_key, m_key);
        chk("core_text", core_text, m_text);
        chk("cipher_out", cipher_out, m_cipher);
        chk("cycles", {112'd0, cycles}, {112'd0, m_cycles});
        chk("timeout", {127'd0, timeout}, {127'd0, m_timeout});
        chk("busy", {127'd0, busy}, {127'd0, exp_busy});
        chk("core_start", {127'd0, core_start}, {127'd0, exp_start});
        chk("trigger", {127'd0, trigger}, {127'd0, exp_trig});
        chk("done", {127'd0, done}, {127'd0, exp_done});
        if (core_start) last_start_cyc = cyc;
    end

    task automatic tick();
        @(posedge crypt_clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_busy = 1'b0; exp_start = 1'b0; exp_trig = 1'b0; exp_done = 1'b0;
    endtask

    task automatic idle(input int n);
        go = 1'b0;
        set_idle_exp();
        repeat (n) tick();
    endtask

    task automatic pulse_reset();
        @(negedge crypt_clk);
        #1;
        crypt_rst_n = 1'b0;
        go = 1'b0;
        #1;
        chk("rst_core_key", core_key, 128'd0);
        chk("rst_core_text", core_text, 128'd0);
        chk("rst_cipher_out", cipher_out, 128'd0);
        chk("rst_cycles", {112'd0, cycles}, 128'd0);
        chk("rst_flags", {122'd0, busy, done, timeout, trigger, core_start, 1'b0}, 128'd0);
        m_key = '0; m_text = '0; m_cipher = '0; m_cycles = '0; m_timeout = 1'b0;
        set_idle_exp();
        tick();
        @(negedge crypt_clk);
        #1;
        crypt_rst_n = 1'b1;
        tick();
    endtask

    // One operation, planned from the go cycle: ready after rdy_lat cycles, core done lat cycles
    // after start (early: done held high through the first RUN cycle), timeout at tlim RUN cycles.
    task automatic run_op(input logic [127:0] k, input logic [127:0] t, input logic [127:0] cv,
                          input int rdy_lat, input int lat, input bit early, input int tlim,
                          input bit go_again, input int rst_at);
        int g, w, s, q, cap, tend, busy_last, trig_last;
        bit to;
        logic pd;
        logic [15:0] v;
        g = cyc;
        w = g + 1 + rdy_lat;
        s = w + 1;
`ifdef CRYPTO_RAND_DELAY_EN
        v = m_lfsr;
        for (int i = 0; i < w - g; i++) v = lfsr_step(v);
        s = w + 2 + int'(v[3:0]);
`else
        v = m_lfsr;
`endif
        q = s + lat;
        to = (tlim != 0) && (tlim < lat);
        tend = s + tlim;
        cap = q + 1;
        busy_last = to ? tend : cap;
        trig_last = to ? tend : q;
        p_go = g;
        pd = core_done;
        timeout_limit = tlim[15:0];
        core_cipher = cv;
        for (int c = g; c <= busy_last + 1; c++) begin
            go = (c == g) || (go_again && c == g + 3);
            key_in  = (c == g) ? k : rand128();
            text_in = (c == g) ? t : rand128();
            core_ready = (rdy_lat == 0) || (c >= w);
            if (c < s + 1 + int'(early)) core_done = early ? 1'b1 : pd;
            else                         core_done = !to && (c >= q);
            exp_busy  = (c > g) && (c <= busy_last);
            exp_start = (c == s);
            exp_trig  = (c >= s) && (c <= trig_last);
            exp_done  = !to && (c == cap);
            if (c == g + 1) begin
                m_key = k; m_text = t; m_timeout = 1'b0;
            end
            if (!to && c == cap) begin
                m_cipher = cv; m_cycles = lat[15:0];
            end
            if (to && c == tend + 1) m_timeout = 1'b1;
            if (rst_at != 0 && c == s + rst_at) begin
                pulse_reset();
                break;
            end
            tick();
        end
        go = 1'b0;
    endtask

    localparam logic [127:0] FIPS_CT = 128'h3925841D02DC09FBDC118597196A0B32;

    initial begin
        int lat, rdy, tl, tsel, lat_min, lat_max, meas;
        bit early;
        repeat (3) @(posedge crypt_clk);
        @(negedge crypt_clk);
        #1;
        crypt_rst_n = 1'b1;
        tick();
        idle(2);

        // Basic op: ready high, core done 10 cycles after start.
        run_op(128'h2B7E151628AED2A6ABF7158809CF4F3C, 128'h3243F6A8885A308D313198A2E0370734,
               FIPS_CT, 0, 10, 1'b0, 0, 1'b0, 0);
        chk("basic_cipher_lit", cipher_out, FIPS_CT);
        chk("basic_cycles_lit", {112'd0, cycles}, 128'd10);
        chk("basic_busy_after", {127'd0, busy}, 128'd0);
`ifndef CRYPTO_RAND_DELAY_EN
        chk("basic_go_to_start", 128'(last_start_cyc - p_go), 128'd2);
`endif
        idle(2);

        // Timeout: core never finishes, limit 5.
        run_op(rand128(), rand128(), rand128(), 0, 1000, 1'b0, 5, 1'b0, 0);
        chk("to_flag_lit", {127'd0, timeout}, 128'd1);
        chk("to_cipher_kept", cipher_out, FIPS_CT);
        chk("to_cycles_kept", {112'd0, cycles}, 128'd10);
        idle(1);

        // Next op clears timeout; early done core.
        run_op(rand128(), rand128(), 128'hA5A5, 0, 6, 1'b1, 0, 1'b0, 0);
        chk("clear_to_lit", {127'd0, timeout}, 128'd0);
        chk("early_cycles_lit", {112'd0, cycles}, 128'd6);
        idle(2);

        // Ready stall of 7 cycles with a second go while busy.
        run_op(rand128(), rand128(), rand128(), 7, 4, 1'b0, 0, 1'b1, 0);
`ifndef CRYPTO_RAND_DELAY_EN
        chk("stall_go_to_start", 128'(last_start_cyc - p_go), 128'd9);
`endif
        idle(3);

        // Coincident done and timeout limit: done wins.
        run_op(rand128(), rand128(), 128'h77, 0, 8, 1'b0, 8, 1'b0, 0);
        chk("coincide_cycles_lit", {112'd0, cycles}, 128'd8);
        idle(1);

        // Reset mid-RUN, then a fresh op.
        run_op(rand128(), rand128(), rand128(), 0, 12, 1'b0, 0, 1'b0, 4);
        idle(2);
        run_op(128'h1, 128'h2, 128'h1234, 0, 3, 1'b0, 0, 1'b0, 0);
        chk("post_rst_cycles_lit", {112'd0, cycles}, 128'd3);
        idle(1);

        for (int n = 0; n < 40; n++) begin
            lat = $urandom_range(2, 20);
            early = (lat >= 3) ? 1'($urandom_range(0, 1)) : 1'b0;
            rdy = $urandom_range(0, 4);
            tsel = $urandom_range(0, 3);
            tl = (tsel == 2) ? $urandom_range(1, 25) : (tsel == 3) ? lat : 0;
            run_op(rand128(), rand128(), rand128(), rdy, lat, early, tl, 1'($urandom_range(0, 1)), 0);
            idle($urandom_range(0, 3));
        end

`ifdef CRYPTO_RAND_DELAY_EN
        lat_min = 1000;
        lat_max = 0;
        for (int n = 0; n < 16; n++) begin
            run_op(rand128(), rand128(), rand128(), 0, 3, 1'b0, 0, 1'b0, 0);
            meas = last_start_cyc - p_go;
            checks++;
            if (meas < 3 || meas > 18) begin
                errors++;
                $display("FAIL jitter_range: actual=%0d required=3..18", meas);
            end
            if (meas < lat_min) lat_min = meas;
            if (meas > lat_max) lat_max = meas;
            idle($urandom_range(0, 2));
        end
        checks++;
        if (lat_min == lat_max) begin
            errors++;
            $display("FAIL jitter_varies: actual=constant %0d required=varying", lat_min);
        end
`else
        lat_min = 0;
        lat_max = 0;
        meas = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=no finish required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
